// File: rtl/sra_seq_pkg.sv
// Shared types for the SRA job sequencer: FSM states, default widths, result entry.
package sra_seq_pkg;

    localparam int unsigned SEQ_DW    = 8;
    localparam int unsigned SEQ_TAG_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StSettle,
        StWait,
        StRecover
    } seq_state_e;

    // One buffered job result at the default widths.
    typedef struct packed {
        logic [SEQ_DW-1:0]    data;
        logic [SEQ_TAG_W-1:0] tag;
        logic                 err;
    } res_entry_t;

endpackage

// File: rtl/sra_result_fifo.sv
// Synchronous show-ahead result buffer with occupancy count.
module sra_result_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       CLR,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pop only when occupied; a push into a full buffer is legal when a pop frees the slot.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q < CW'(DEPTH)) || do_pop);
    end

    // Storage needs no reset: the head is gated by valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (CLR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign valid = (count_q != '0);
    assign head  = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/sra_job_sequencer.sv
// Job sequencer for the square-root unit: accepts operands, launches the unit, waits for
// Done under a watchdog, and buffers tagged results.
module sra_job_sequencer
    import sra_seq_pkg::*;
#(
    parameter int unsigned DW         = SEQ_DW,
    parameter int unsigned TAG_W      = SEQ_TAG_W,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [DW-1:0]    op_a,
    input  logic [DW-1:0]    op_b,
    output logic [DW-1:0]    sra_in1,
    output logic [DW-1:0]    sra_in2,
    output logic             sra_start,
    output logic             sra_clr,
    input  logic             sra_done,
    input  logic [DW-1:0]    sra_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW   = DW + TAG_W + 1;

    seq_state_e       state_q, state_d;
    logic [DW-1:0]    in1_q, in2_q;
    logic [TAG_W-1:0] tag_q, tag_ctr_q;
    logic [WD_W-1:0]  wd_q;
    logic             accept, wd_inc, push, push_err;
    logic [EW-1:0]    push_data, head;
    logic [CW-1:0]    fifo_count;

    // Ready depends only on state and buffer space so every pushed result is guaranteed a slot.
    assign op_ready = (state_q == StIdle) && (fifo_count < CW'(FIFO_DEPTH));

    // Next-state and per-state strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        wd_inc   = 1'b0;
        push     = 1'b0;
        push_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (op_valid && op_ready) begin
                    accept  = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: state_d = StSettle;
            // Done may still be high from the previous job here, so it is not looked at.
            StSettle: state_d = StWait;
            StWait: begin
                if (sra_done) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    state_d  = StRecover;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State, operand/tag capture and watchdog registers.
    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q   <= StIdle;
            in1_q     <= '0;
            in2_q     <= '0;
            tag_q     <= '0;
            tag_ctr_q <= '0;
            wd_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                in1_q     <= op_a;
                in2_q     <= op_b;
                tag_q     <= tag_ctr_q;
                tag_ctr_q <= tag_ctr_q + TAG_W'(1);
            end
            if (state_q == StSettle) begin
                wd_q <= '0;
            end else if (wd_inc) begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end

    assign push_data = {(push_err ? {DW{1'b0}} : sra_out), tag_q, push_err};

    sra_result_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .CLR       (CLR),
        .push      (push),
        .push_data (push_data),
        .pop       (res_ready),
        .head      (head),
        .valid     (res_valid),
        .count     (fifo_count)
    );

    assign res_data  = head[EW-1 -: DW];
    assign res_tag   = head[TAG_W:1];
    assign res_err   = head[0];
    assign sra_in1   = in1_q;
    assign sra_in2   = in2_q;
    assign sra_start = (state_q == StLaunch);
    assign sra_clr   = CLR | (state_q == StRecover);
    assign busy      = (state_q != StIdle);

endmodule
